// File: rtl/bvmul_ugt_skolem_seq.sv
// Sequential Skolem witness search for exists x. (a*x mod 2^W) >u c, using a shared shift-add multiplier.
// Optional macro SKOLEM_EARLY_EXIT_EN: trivially unsatisfiable requests (c all-ones or a zero) finish immediately.
module bvmul_ugt_skolem_seq #(
  parameter int unsigned W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] a,
  input  logic [W-1:0] c,
  output logic         ready,
  output logic         busy,
  output logic         done,
  output logic         found,
  output logic [W-1:0] witness
);

  localparam int unsigned CW = (W > 1) ? $clog2(W) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_MUL,
    S_CMP,
    S_DONE
  } state_t;

  state_t         state_q, state_d;
  logic [W-1:0]   a_q, a_d;
  logic [W-1:0]   c_q, c_d;
  logic [W-1:0]   x_q, x_d;
  logic [W-1:0]   acc_q, acc_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           found_q, found_d;
  logic [W-1:0]   witness_q, witness_d;

  logic [W-1:0]   partial;
  logic           last_step;

  // One partial product per cycle, LSB-first over x; the W-bit sum drops carries (mod 2^W).
  assign partial   = x_q[cnt_q] ? (a_q << cnt_q) : '0;
  assign last_step = (cnt_q == CW'(W - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      a_q       <= '0;
      c_q       <= '0;
      x_q       <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      found_q   <= 1'b0;
      witness_q <= '0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      c_q       <= c_d;
      x_q       <= x_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      found_q   <= found_d;
      witness_q <= witness_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    c_d       = c_q;
    x_d       = x_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    found_d   = found_q;
    witness_d = witness_q;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          a_d   = a;
          c_d   = c;
          x_d   = '0;
          acc_d = '0;
          cnt_d = '0;
`ifdef SKOLEM_EARLY_EXIT_EN
          if ((c == '1) || (a == '0)) begin
            found_d   = 1'b0;
            witness_d = '0;
            state_d   = S_DONE;
          end else begin
            state_d = S_MUL;
          end
`else
          state_d = S_MUL;
`endif
        end
      end

      S_MUL: begin
        acc_d = acc_q + partial;
        if (last_step) begin
          cnt_d   = '0;
          state_d = S_CMP;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      S_CMP: begin
        if (acc_q > c_q) begin
          found_d   = 1'b1;
          witness_d = x_q;
          state_d   = S_DONE;
        end else if (x_q == '1) begin
          found_d   = 1'b0;
          witness_d = '0;
          state_d   = S_DONE;
        end else begin
          x_d     = x_q + W'(1);
          acc_d   = '0;
          cnt_d   = '0;
          state_d = S_MUL;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign ready   = (state_q == S_IDLE);
  assign busy    = (state_q != S_IDLE);
  assign done    = (state_q == S_DONE);
  assign found   = found_q;
  assign witness = witness_q;

endmodule

// File: doc/bvmul_ugt_skolem_seq.md
Name: bvmul_ugt_skolem_seq

Overview:
- Sequential witness generator for the bit-vector constraint ∃x. bvugt(bvmul(a,x), c), all operands W-bit unsigned, products taken mod 2^W.
- On start, latches a and c, then enumerates candidate x = 0,1,2,… in ascending order.
- Each candidate's product comes from a shared shift-add multiplier; the block then does one unsigned compare against c.
- Reports the smallest satisfying x as the Skolem witness, or reports not-found after all 2^W candidates are exhausted.

Parameters:
- W, 4, operand/witness width in bits (legal range 2..16).

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request pulse; sampled only while ready=1.
- a  input  W  multiplicand; latched when start is accepted.
- c  input  W  compare bound; latched when start is accepted.
- ready  output  1  high in IDLE; start is accepted only when high.
- busy  output  1  high in MUL, CMP and DONE.
- done  output  1  one-cycle pulse; high only in DONE.
- found  output  1  result valid from DONE onward: 1 = witness exists.
- witness  output  W  smallest x with (a*x mod 2^W) > c; 0 when found=0.

Behaviour:
- Reset, applied at any time including mid-search, has the following effect on the next edge:
  - state=IDLE, ready=1, busy=0, done=0, found=0, witness=0;
  - internal x, product accumulator and bit counter cleared.
- States: IDLE, MUL, CMP, DONE.
- IDLE:
  - on start=1: latch a→A and c→C, set x=0, clear accumulator and bit counter, go to MUL;
  - found and witness hold their previous results until the next accepted start.
- MUL:
  - exactly W cycles, one shift-add step per cycle (LSB-first over x);
  - accumulator is W bits wide; carries past bit W-1 are discarded, i.e. mod 2^W;
  - after the W-th step go to CMP.
- CMP (1 cycle), unsigned compare of P = A*x mod 2^W against C:
  - if P > C: found=1, witness=x, go to DONE;
  - else if x = 2^W-1: found=0, witness=0, go to DONE;
  - else x=x+1, clear accumulator and bit counter, go to MUL.
- DONE: done=1 for exactly one cycle, then IDLE; found and witness remain stable.
- Latency:
  - done is high in cycle N = 1 + (k+1)*(W+1) after the start-sampling edge, where k is the witness value;
  - for not-found, k = 2^W-1 (with the optional feature below disabled).
- start while busy is ignored; there is no queueing.
- a and c changing after acceptance have no effect.
- The compare is strictly greater-than: P = C is a miss.
- x never wraps, since the search terminates at 2^W-1.

Optional Feature:
- Macro: SKOLEM_EARLY_EXIT_EN.
- Defined:
  - in IDLE, when start is accepted with c = all-ones, go directly to DONE with found=0, witness=0; done asserts 1 cycle after acceptance;
  - in IDLE, when start is accepted with a = 0, the same early exit applies, since P is always 0 and 0 > c is impossible.
- Undefined: no early exit; these cases run the full 2^W-candidate search, done at N = 1 + 2^W*(W+1).

Test Plan (all with W=4):
- a=3, c=5, start one cycle → found=1, witness=2, done pulse at cycle 16, single cycle wide.
- a=6, c=13 (product wrap: 18→2, 24→8, 30→14) → found=1, witness=5, done at cycle 31.
- a=1, c=0 (x=0 gives P=0, equality is not a hit) → found=1, witness=1, done at cycle 11.
- a=7, c=15:
  - macro undefined → found=0, witness=0, done at cycle 81;
  - macro defined → done at cycle 1.
  - a=0, c=3 with macro defined → done at cycle 1, found=0.
- Start a=3, c=5; pulse start again with a=1, c=0 at cycle 4 → second start ignored, result still witness=2 at cycle 16. Then assert rst at cycle 8 of a fresh search → next cycle ready=1, busy=0, found=0, witness=0, and no done pulse.
- Back-to-back: start a=3, c=5 in the cycle ready returns after the first done → second result witness=2 at cycle 16. Between the two runs, found=1 and witness=2 hold stable.
